// File: rtl/video_dram_sched.sv
// Per-DRAM-cycle scheduler sharing one DRAM port between video, CPU and refresh.
// Video slots are reserved by bandwidth; free slots go to refresh, then CPU.
module video_dram_sched #(
  parameter int REF_PERIOD = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cend,
  input  logic        go,
  input  logic [1:0]  bw,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        video_strobe,
  output logic [15:0] video_data,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wrdata,
  input  logic [1:0]  cpu_bsel,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic [15:0] cpu_rddata,
  output logic        dram_req,
  output logic        dram_ref,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [15:0] dram_wrdata,
  output logic [1:0]  dram_bsel,
  input  logic        dram_rdy,
  input  logic [15:0] dram_rd
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPUR = 2'd2;
  localparam logic [1:0] OWN_CPUW = 2'd3;

  localparam logic [7:0] REF_LAST = 8'(REF_PERIOD - 1);

  logic [3:0] slot;
  logic [7:0] ref_cnt;
  logic       ref_pend;
  logic       ref_wrap;
  logic [1:0] owner;
  logic       vid_slot;
  logic       vid_grant;
  logic       cpu_grant;
  logic       ref_grant;

  always_comb begin
    vid_slot = 1'b0;
    if (go) begin
      case (bw)
        2'b00:   vid_slot = (slot[2:0] == 3'd0);
        2'b01:   vid_slot = (slot[1:0] == 2'd0);
        2'b10:   vid_slot = (slot[0] == 1'b0);
        default: vid_slot = 1'b1;
      endcase
    end
  end

  assign vid_grant = cend & vid_slot;
  assign ref_grant = cend & ~vid_slot & ref_pend;
  assign cpu_grant = cend & ~vid_slot & ~ref_pend & cpu_req;
  assign ref_wrap  = cend & (ref_cnt == REF_LAST);

  // Grants are combinational; mask them while reset is held so every output reads 0.
  assign video_next = vid_grant & ~rst;
  assign cpu_next   = cpu_grant & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (!go) begin
      slot <= '0;
    end else if (cend) begin
      slot <= slot + 4'd1;
    end
  end

  // A wrap coinciding with a refresh issue keeps the request pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else if (cend) begin
      ref_cnt <= ref_wrap ? 8'd0 : ref_cnt + 8'd1;
      if (ref_wrap) begin
        ref_pend <= 1'b1;
      end else if (ref_grant) begin
        ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_req    <= 1'b0;
      dram_ref    <= 1'b0;
      dram_rnw    <= 1'b0;
      dram_addr   <= '0;
      dram_wrdata <= '0;
      dram_bsel   <= '0;
      owner       <= OWN_NONE;
    end else if (cend) begin
      dram_req <= vid_grant | cpu_grant;
      dram_ref <= ref_grant;
      if (vid_grant) begin
        dram_rnw  <= 1'b1;
        dram_addr <= video_addr;
        dram_bsel <= '1;
        owner     <= OWN_VID;
      end else if (cpu_grant) begin
        dram_rnw    <= cpu_rnw;
        dram_addr   <= cpu_addr;
        dram_wrdata <= cpu_wrdata;
        dram_bsel   <= cpu_rnw ? 2'b11 : cpu_bsel;
        owner       <= cpu_rnw ? OWN_CPUR : OWN_CPUW;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_strobe <= 1'b0;
      video_data   <= '0;
      cpu_strobe   <= 1'b0;
      cpu_rddata   <= '0;
    end else begin
      video_strobe <= dram_rdy & (owner == OWN_VID);
      cpu_strobe   <= dram_rdy & (owner == OWN_CPUR);
      if (dram_rdy && owner == OWN_VID) begin
        video_data <= dram_rd;
      end
      if (dram_rdy && owner == OWN_CPUR) begin
        cpu_rddata <= dram_rd;
      end
    end
  end

endmodule

// File: tb/tb_video_dram_sched.sv
// Directed bench for video_dram_sched with REF_PERIOD=16.
module tb_video_dram_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cend = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  bw = 2'b00;
  logic [20:0] video_addr = '0;
  logic        video_next, video_strobe;
  logic [15:0] video_data;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic [20:0] cpu_addr = '0;
  logic [15:0] cpu_wrdata = '0;
  logic [1:0]  cpu_bsel = 2'b11;
  logic        cpu_next, cpu_strobe;
  logic [15:0] cpu_rddata;
  logic        dram_req, dram_ref, dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata;
  logic [1:0]  dram_bsel;
  logic        dram_rdy = 1'b0;
  logic [15:0] dram_rd = '0;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic vn, cn;

  always #5 clk = ~clk;

  video_dram_sched #(.REF_PERIOD(16)) dut (
    .clk(clk), .rst(rst), .cend(cend), .go(go), .bw(bw),
    .video_addr(video_addr), .video_next(video_next),
    .video_strobe(video_strobe), .video_data(video_data),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_bsel(cpu_bsel), .cpu_next(cpu_next),
    .cpu_strobe(cpu_strobe), .cpu_rddata(cpu_rddata),
    .dram_req(dram_req), .dram_ref(dram_ref), .dram_rnw(dram_rnw),
    .dram_addr(dram_addr), .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
    .dram_rdy(dram_rdy), .dram_rd(dram_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One DRAM cycle: cend for one clock, one idle clock; returns at a negedge.
  task automatic tick_cend();
    @(negedge clk);
    cend = 1'b1;
    #1;
    vn = video_next;
    cn = cpu_next;
    @(negedge clk);
    cend = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rdy_pulse(input logic [15:0] d);
    @(negedge clk);
    dram_rdy = 1'b1;
    dram_rd  = d;
    #1;
    check("strobe_not_same_clk", {30'd0, video_strobe, cpu_strobe}, 32'd0);
    @(negedge clk);
    dram_rdy = 1'b0;
  endtask

  initial begin
    int vcnt, ccnt, rcnt;
    logic ev, er, ec;

    // Reset state
    #2;
    check("rst_dram_req", {31'd0, dram_req}, 32'd0);
    check("rst_dram_addr", {11'd0, dram_addr}, 32'd0);
    check("rst_strobes", {30'd0, video_strobe, cpu_strobe}, 32'd0);
    do_reset();

    // bw=00, cpu_req held, 32 cends: video at slots 0/8, refresh at cend 18
    bw = 2'b00; go = 1'b1; cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h155AA;
    vcnt = 0; ccnt = 0;
    for (int k = 1; k <= 32; k++) begin
      video_addr = 21'(32'h10000 + k);
      tick_cend();
      ev = ((k - 1) % 8 == 0);
      er = (k == 18);
      ec = !ev && !er;
      vcnt += int'(vn);
      ccnt += int'(cn);
      check($sformatf("bw0_vnext_%0d", k), {31'd0, vn}, {31'd0, ev});
      check($sformatf("bw0_cnext_%0d", k), {31'd0, cn}, {31'd0, ec});
      check($sformatf("bw0_ref_%0d", k), {31'd0, dram_ref}, {31'd0, er});
      if (ev) begin
        check($sformatf("bw0_vaddr_%0d", k), {11'd0, dram_addr}, 32'h10000 + k);
        check($sformatf("bw0_vbsel_%0d", k), {30'd0, dram_bsel}, 32'd3);
      end else if (ec) begin
        check($sformatf("bw0_caddr_%0d", k), {11'd0, dram_addr}, 32'h155AA);
      end
    end
    check("bw0_vid_count", vcnt, 4);
    check("bw0_cpu_count", ccnt, 27);
    go = 1'b0; cpu_req = 1'b0;

    // bw=01 and bw=10 slot counts
    for (int b = 1; b <= 2; b++) begin
      do_reset();
      bw = 2'(b); go = 1'b1;
      vcnt = 0;
      for (int k = 1; k <= 16; k++) begin
        tick_cend();
        if (k == 1) check($sformatf("bw%0d_slot0_video", b), {31'd0, vn}, 32'd1);
        vcnt += int'(vn);
      end
      check($sformatf("bw%0d_vid_count", b), vcnt, (b == 1) ? 4 : 8);
      go = 1'b0;
    end

    // Refresh pressure: 8 cends go=0, 40 cends bw=11, then go falls
    do_reset();
    bw = 2'b11; go = 1'b0; cpu_req = 1'b1; cpu_rnw = 1'b1;
    ccnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick_cend();
      ccnt += int'(cn);
    end
    check("pre_cpu_count", ccnt, 8);
    go = 1'b1;
    vcnt = 0; ccnt = 0; rcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick_cend();
      vcnt += int'(vn);
      ccnt += int'(cn);
      rcnt += int'(dram_ref);
    end
    check("bw3_vid_count", vcnt, 40);
    check("bw3_cpu_count", ccnt, 0);
    check("bw3_ref_count", rcnt, 0);
    go = 1'b0;
    tick_cend();
    check("after_go_ref", {31'd0, dram_ref}, 32'd1);
    check("after_go_req", {31'd0, dram_req}, 32'd0);
    check("after_go_cnext0", {31'd0, cn}, 32'd0);
    tick_cend();
    check("after_go_cnext1", {31'd0, cn}, 32'd1);
    check("after_go_ref1", {31'd0, dram_ref}, 32'd0);
    tick_cend();
    check("after_go_cnext2", {31'd0, cn}, 32'd1);
    cpu_req = 1'b0;

    // Read routing
    do_reset();
    bw = 2'b00; go = 1'b0;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0ABCD;
    tick_cend();
    cpu_req = 1'b0;
    check("cpurd_next", {31'd0, cn}, 32'd1);
    check("cpurd_addr", {11'd0, dram_addr}, 32'h0ABCD);
    check("cpurd_rnw", {31'd0, dram_rnw}, 32'd1);
    check("cpurd_bsel", {30'd0, dram_bsel}, 32'd3);
    rdy_pulse(16'h1234);
    check("cpurd_strobe", {31'd0, cpu_strobe}, 32'd1);
    check("cpurd_vstrobe", {31'd0, video_strobe}, 32'd0);
    check("cpurd_data", {16'd0, cpu_rddata}, 32'h1234);
    @(negedge clk);
    check("cpurd_strobe_width", {31'd0, cpu_strobe}, 32'd0);
    check("cpurd_data_hold", {16'd0, cpu_rddata}, 32'h1234);
    go = 1'b1; video_addr = 21'h1F000;
    tick_cend();
    go = 1'b0;
    check("vrd_next", {31'd0, vn}, 32'd1);
    check("vrd_addr", {11'd0, dram_addr}, 32'h1F000);
    rdy_pulse(16'h5678);
    check("vrd_strobe", {31'd0, video_strobe}, 32'd1);
    check("vrd_cstrobe", {31'd0, cpu_strobe}, 32'd0);
    check("vrd_data", {16'd0, video_data}, 32'h5678);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h00123; cpu_wrdata = 16'hBEEF; cpu_bsel = 2'b01;
    tick_cend();
    cpu_req = 1'b0;
    check("wr_next", {31'd0, cn}, 32'd1);
    check("wr_rnw", {31'd0, dram_rnw}, 32'd0);
    check("wr_bsel", {30'd0, dram_bsel}, 32'd1);
    check("wr_data", {16'd0, dram_wrdata}, 32'hBEEF);
    rdy_pulse(16'h9999);
    check("wr_no_strobe", {30'd0, video_strobe, cpu_strobe}, 32'd0);
    check("wr_vdata_hold", {16'd0, video_data}, 32'h5678);
    tick_cend();
    check("idle_req", {30'd0, dram_req, dram_ref}, 32'd0);
    check("idle_addr_hold", {11'd0, dram_addr}, 32'h00123);

    // Asynchronous reset during a video access
    go = 1'b1; video_addr = 21'h0F0F0;
    tick_cend();
    check("pre_rst_req", {31'd0, dram_req}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {30'd0, dram_req, dram_ref}, 32'd0);
    check("arst_rnw_bsel", {29'd0, dram_rnw, dram_bsel}, 32'd0);
    check("arst_addr", {11'd0, dram_addr}, 32'd0);
    check("arst_wrdata", {16'd0, dram_wrdata}, 32'd0);
    check("arst_vdata", {16'd0, video_data}, 32'd0);
    check("arst_cdata", {16'd0, cpu_rddata}, 32'd0);
    check("arst_nexts", {28'd0, video_next, cpu_next, video_strobe, cpu_strobe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rdy_pulse(16'hAAAA);
    check("post_rst_no_strobe", {30'd0, video_strobe, cpu_strobe}, 32'd0);
    tick_cend();
    check("post_rst_slot0", {31'd0, vn}, 32'd1);
    check("post_rst_addr", {11'd0, dram_addr}, 32'h0F0F0);
    go = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
